gcd_operand_feeder: RTL
=======================

Name: gcd_operand_feeder

Overview:
Upstream stage for the iterative gcd core. It queues operand pairs from a valid/ready producer in a small FIFO and issues them one at a time to the core over the core's opa/opb/start/done interface. It captures each result, with the originating operands, into a single-entry valid/ready output register. Zero-operand pairs are resolved locally without using the core, and a watchdog flags a core that never completes.

Parameters:
WIDTH, 32, operand/result width
DEPTH, 4, FIFO entries; power of two, >= 2
TIMEOUT, 1024, max cycles in RUN before an error result is forced

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  producer has an operand pair
in_ready  output  1  FIFO can accept; equals (count < DEPTH)
in_opa  input  WIDTH  operand A
in_opb  input  WIDTH  operand B
opa  output  WIDTH  operand A to gcd core, registered
opb  output  WIDTH  operand B to gcd core, registered
start  output  1  start to gcd core, registered
core_done  input  1  done from gcd core
core_result  input  WIDTH  result from gcd core
out_valid  output  1  output register holds a result
out_ready  input  1  consumer accepts
out_result  output  WIDTH  gcd value
out_opa  output  WIDTH  operand A of this result
out_opb  output  WIDTH  operand B of this result
out_err  output  1  result produced by timeout
count  output  $clog2(DEPTH)+1  FIFO occupancy
busy  output  1  FSM not in IDLE

Behaviour:
- Reset, synchronous and active-high, clock clk: FSM=IDLE; FIFO empty, count=0; start=0, opa=opb=0; out_valid=0, out_result=out_opa=out_opb=0, out_err=0; watchdog=0. Reset overrides all activity, including mid-RUN. The core is left to its own reset.
- FIFO:
  - Push on in_valid&&in_ready.
  - Pop only when the FSM leaves IDLE.
  - Push and pop in the same cycle are legal when not full; count is unchanged.
  - When full, in_ready=0 regardless of a same-cycle pop.
  - Entries are served strictly in order.
- Output register:
  - Loads when the FSM writes a result.
  - Clears out_valid on out_valid&&out_ready.
  - Contents held stable while out_valid=1 and out_ready=0.
- FSM states: IDLE, BYPASS, RUN, RELEASE.
  - IDLE:
    - If FIFO non-empty and out_valid=0, or out_valid&&out_ready this cycle: pop head into opa/opb.
    - If either operand is 0: go to BYPASS.
    - Otherwise: set start=1, go to RUN.
  - BYPASS, one cycle: write output with out_result = (opa==0 ? opb : opa), so gcd(0,0)=0; out_err=0; go to IDLE. start stays 0 throughout.
  - RUN:
    - start=1; opa/opb held stable; watchdog increments each cycle.
    - On core_done=1: capture core_result into output, out_err=0, start=0, go to RELEASE.
    - If watchdog reaches TIMEOUT-1 with no done: write out_result=0, out_err=1, start=0, go to RELEASE.
  - RELEASE: start=0 for exactly one cycle so the core sees a fresh start edge; watchdog cleared; go to IDLE.
- Latency from the accepting push edge (T), with FIFO and output initially empty:
  - FIFO head visible at T+1.
  - start=1 at T+2.
  - out_valid=1 the cycle after core_done is sampled high.
  - Bypass case: out_valid=1 at T+3.
- Minimum spacing between consecutive core starts is 2 cycles of start=0 (RELEASE plus IDLE).
- A new issue never occurs while the output register is occupied and not being drained. Therefore a completion always has a free slot.
- core_done while not in RUN is ignored.
- busy=1 in BYPASS, RUN and RELEASE.

Test Plan:
1. Reset; push (1071,462); core model asserts core_done with core_result=21 after 6 cycles of start -> start=1 at T+2; out_valid=1, out_result=21, out_opa=1071, out_opb=462, out_err=0; start=0 in RELEASE.
2. Zero bypass: push (0,35), then (0,0) -> results 35 then 0; out_valid for the first at T+3; start never asserted.
3. Full FIFO: stall the core by holding core_done=0, with TIMEOUT large; push 5 pairs -> 1 issued to the core, 4 queued, count=4, in_ready=0, 6th push refused. Release the core -> results emerge in push order.
4. Backpressure: out_ready=0 with 2 pairs queued -> first result held stable; no second start until out_ready=1 handshake; second start follows within 2 cycles.
5. Timeout with TIMEOUT=16: core_done never rises -> after 16 RUN cycles out_valid=1, out_err=1, out_result=0; next pair still issued normally.
6. Reset mid-RUN with 2 entries queued -> next cycle start=0, count=0, out_valid=0, busy=0; pair pushed after reset completes normally.

Source files
------------

// File: rtl/gcd_operand_feeder.sv
// Operand feeder for the iterative gcd core: FIFO of operand pairs, issue FSM,
// zero-operand bypass, RUN watchdog and a single-entry result register.
module gcd_operand_feeder #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_opa,
  input  logic [WIDTH-1:0]       in_opb,
  output logic [WIDTH-1:0]       opa,
  output logic [WIDTH-1:0]       opb,
  output logic                   start,
  input  logic                   core_done,
  input  logic [WIDTH-1:0]       core_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_result,
  output logic [WIDTH-1:0]       out_opa,
  output logic [WIDTH-1:0]       out_opb,
  output logic                   out_err,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  FULL    = CW'(DEPTH);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } pair_t;

  typedef enum logic [1:0] {IDLE, BYPASS, RUN, RELEASE} state_t;

  state_t           state;
  pair_t            mem [DEPTH-1:0];
  pair_t            head;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [WDW-1:0]   wdog;
  logic             push, pop, out_free;
  logic             wr_res, res_err;
  logic [WIDTH-1:0] res_val;

  assign in_ready = (count < FULL);
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];
  assign out_free = !out_valid || out_ready;
  // Issue only when the result slot is free or draining, so a completion never stalls.
  assign pop      = (state == IDLE) && (count != '0) && out_free;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{a: in_opa, b: in_opb};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Result source: bypass value, core result, or forced timeout error.
  always_comb begin
    wr_res  = 1'b0;
    res_err = 1'b0;
    res_val = '0;
    case (state)
      BYPASS: begin
        wr_res  = 1'b1;
        res_val = (opa == '0) ? opb : opa;
      end
      RUN: begin
        if (core_done) begin
          wr_res  = 1'b1;
          res_val = core_result;
        end else if (wdog == WD_LAST) begin
          wr_res  = 1'b1;
          res_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      start <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      wdog  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            opa <= head.a;
            opb <= head.b;
            if (head.a == '0 || head.b == '0) begin
              state <= BYPASS;
            end else begin
              start <= 1'b1;
              state <= RUN;
            end
          end
        end
        BYPASS: state <= IDLE;
        RUN: begin
          if (wr_res) begin
            start <= 1'b0;
            state <= RELEASE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        // One start-low cycle guarantees the core sees a fresh rising start.
        RELEASE: begin
          wdog  <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_opa    <= '0;
      out_opb    <= '0;
      out_err    <= 1'b0;
    end else if (wr_res) begin
      out_valid  <= 1'b1;
      out_result <= res_val;
      out_opa    <= opa;
      out_opb    <= opb;
      out_err    <= res_err;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
